edge_event_arbiter: RTL and testbench
=====================================

Name: edge_event_arbiter

Overview:
Multi-channel edge-event scheduler. Each of N_CH asynchronous inputs is synchronised and edge-detected with a per-channel configurable mode. Detected edges are latched as pending events. A round-robin arbiter then serialises the events onto a single valid/ready event port. It sits between raw board signals (buttons, sensor strobes) and a single downstream consumer such as an event FIFO or a control FSM.

Parameters:
N_CH, 4, number of input channels (2..16)
CH_W, $clog2(N_CH), width of the channel index (derived; do not override)

Ports:
sys_clk  in  1  system clock; all logic on rising edge
sys_rst  in  1  synchronous, active-high reset
sig_in  in  N_CH  raw asynchronous inputs
ch_en  in  N_CH  per-channel enable
edge_sel  in  2*N_CH  per-channel mode; bits [2i+1:2i] for channel i; 00 off, 01 rise, 10 fall, 11 both
evt_valid  out  1  event offered
evt_ready  in  1  consumer accepts the event
evt_ch  out  CH_W  index of the channel offered
evt_rise  out  1  1 = offered edge was rising, 0 = falling
ovf  out  N_CH  sticky per-channel overflow (an edge was lost)
ovf_clr  in  N_CH  per-channel overflow clear strobe

Behaviour:
- Clock and reset: one clock, sys_clk. Reset is synchronous, active-high, named sys_rst.
- Reset: every register clears to 0, including the sync and history flops, the pending and polarity registers, ovf, evt_valid, evt_ch and evt_rise. The last-grant pointer resets to N_CH-1, so channel 0 has first priority.
- Per-channel pipeline: s1 <= sig_in, s2 <= s1, s3 <= s2.
  - rise = s2 & ~s3; fall = ~s2 & s3.
  - A detected edge (det) is (rise & sel[0]) | (fall & sel[1]), qualified by ch_en.
- Latency: sig_in is first sampled high at edge k. pending[i] is set at edge k+3. evt_valid can assert no earlier than edge k+4.
- After reset, an input held high produces a rise event (history starts at 0). This is intended behaviour.
- Pending register per channel:
  - det sets pending[i] and loads pol[i] = rise.
  - det while pending[i] is already 1 (and the channel is not completing a handshake that cycle) sets ovf[i]. pol[i] is overwritten with the newer edge.
  - A handshake on channel i clears pending[i]. If det[i] occurs in the same cycle, pending stays 1 with the new pol, and ovf is not set.
  - ch_en[i] = 0 clears pending[i] unless channel i is currently offered.
- ovf[i] clears when ovf_clr[i] = 1. If a set and a clear coincide, set wins.
- Arbiter FSM with two states:
  - IDLE: if any pending bit is set, select the first pending channel searching from last_grant+1 with wrap modulo N_CH. Register evt_ch and evt_rise = pol[ch], assert evt_valid, and go to OFFER.
  - OFFER: evt_valid, evt_ch and evt_rise stay stable until evt_ready = 1. On that handshake: clear pending, set last_grant = evt_ch, deassert evt_valid, and return to IDLE.
- Throughput: at most one event every 2 cycles.
- Valid stability: evt_valid never drops without a handshake, except on reset.
- A pol update on the offered channel while in OFFER does not change evt_rise. The new edge remains pending as a separate event.
- Changes to edge_sel take effect on the next cycle's detection only. Already-pending events are unaffected.

Decomposition:
- Package edge_evt_pkg holds:
  - edge_sel encoding constants: EDGE_OFF, EDGE_RISE, EDGE_FALL, EDGE_BOTH.
  - FSM state typedef (IDLE, OFFER).
  - Round-robin next-index function.
- Sub-module edge_detect_ch: 3-flop sync/history, mode decode, rise/fall/det outputs. It is instantiated N_CH times.
- The top level holds pending/pol/ovf and the arbiter. Expected size is about 200 lines.

Test Plan:
- Single rise: ch_en = 4'b0001, edge_sel = 8'h01, sig_in[0] 0->1 with evt_ready = 1 -> exactly one handshake, evt_ch = 0, evt_rise = 1, evt_valid asserted 4 cycles after the first high sample, ovf = 0.
- Round-robin: all channels enabled in mode 01, sig_in 4'h0 -> 4'hF in one cycle, evt_ready = 1 -> handshakes in order evt_ch 0,1,2,3, each 2 cycles apart; then last_grant = 3.
- Backpressure and overflow: channel 2 in mode 11, evt_ready = 0, sig_in[2] toggles 0->1->0 (3 cycles per level) -> evt_ch = 2, evt_rise = 1 held stable while waiting; ovf[2] = 1. After evt_ready = 1, a second event with evt_rise = 0 follows. ovf_clr[2] then clears ovf[2].
- Simultaneous handshake and new edge: channel 1 offered; a new det[1] lands in the handshake cycle -> pending[1] stays set, ovf[1] stays 0, and a second channel-1 event is offered 2 cycles later.
- Disable and mode: channel 3 has an edge pending while not offered, then ch_en[3] -> 0 -> no channel-3 event. With edge_sel = 2'b10, a rising input produces no event and a falling input produces evt_rise = 0.
- Mid-offer reset: sys_rst = 1 for 1 cycle during OFFER -> evt_valid = 0, ovf = 0 the next cycle. A high sig_in[0] then produces a fresh rise event after release.

Source files
------------

// File: rtl/edge_evt_pkg.sv
// edge_evt_pkg: edge-mode encodings, arbiter state type and round-robin search helper
package edge_evt_pkg;

    localparam logic [1:0] EDGE_OFF  = 2'b00;
    localparam logic [1:0] EDGE_RISE = 2'b01;
    localparam logic [1:0] EDGE_FALL = 2'b10;
    localparam logic [1:0] EDGE_BOTH = 2'b11;

    typedef enum logic {IDLE, OFFER} arb_state_t;

    // First set bit of pend searching from last+1 upward, wrapping at n; returns last when none is set
    function automatic int rr_next(input logic [15:0] pend, input int last, input int n);
        int   sel;
        int   idx;
        logic found;
        sel   = last;
        found = 1'b0;
        for (int k = 1; k <= 16; k++) begin
            idx = (last + k) % n;
            if (k <= n && !found && pend[idx[3:0]]) begin
                sel   = idx;
                found = 1'b1;
            end
        end
        return sel;
    endfunction

endpackage

// File: rtl/edge_detect_ch.sv
// edge_detect_ch: one channel's synchroniser, edge history and mode-qualified edge detect
module edge_detect_ch
    import edge_evt_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       sig,
    input  logic       en,
    input  logic [1:0] sel,
    output logic       rise,
    output logic       fall,
    output logic       det
);
    logic s1, s2, s3;

    // Two-flop synchroniser plus history flop; edge pulses are registered so a
    // new level reaches the pending register three edges after its first sample
    always_ff @(posedge clk) begin
        if (rst) begin
            s1   <= 1'b0;
            s2   <= 1'b0;
            s3   <= 1'b0;
            rise <= 1'b0;
            fall <= 1'b0;
        end else begin
            s1   <= sig;
            s2   <= s1;
            s3   <= s2;
            rise <= s2 & ~s3;
            fall <= ~s2 & s3;
        end
    end

    assign det = en & (sel != EDGE_OFF) &
                 ((rise & (sel == EDGE_RISE || sel == EDGE_BOTH)) |
                  (fall & (sel == EDGE_FALL || sel == EDGE_BOTH)));

endmodule

// File: rtl/edge_event_arbiter.sv
// edge_event_arbiter: latches per-channel edge events and serialises them round-robin onto one valid/ready port
module edge_event_arbiter
    import edge_evt_pkg::*;
#(
    parameter  int N_CH = 4,
    localparam int CH_W = $clog2(N_CH)
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic [N_CH-1:0]   sig_in,
    input  logic [N_CH-1:0]   ch_en,
    input  logic [2*N_CH-1:0] edge_sel,
    output logic              evt_valid,
    input  logic              evt_ready,
    output logic [CH_W-1:0]   evt_ch,
    output logic              evt_rise,
    output logic [N_CH-1:0]   ovf,
    input  logic [N_CH-1:0]   ovf_clr
);
    logic [N_CH-1:0] rise, fall, det, pending, pol, offered, done;
    logic [N_CH-1:0] pending_n, pol_n, ovf_n;
    logic [CH_W-1:0] last_grant, next_ch, ch_n;
    logic            rise_n, renew, renew_n;
    arb_state_t      state, state_n;

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        edge_detect_ch u_det (
            .clk  (sys_clk),
            .rst  (sys_rst),
            .sig  (sig_in[i]),
            .en   (ch_en[i]),
            .sel  (edge_sel[2*i+1:2*i]),
            .rise (rise[i]),
            .fall (fall[i]),
            .det  (det[i])
        );
    end

    assign evt_valid = state == OFFER;
    assign offered   = evt_valid ? (N_CH'(1) << evt_ch) : '0;
    assign done      = offered & {N_CH{evt_ready}};
    assign next_ch   = CH_W'(rr_next(16'(pending), int'(last_grant), N_CH));

    // A handshake retires the pending bit unless a newer edge arrived while offered (renew);
    // the offered channel keeps its pending state even if disabled mid-offer
    assign pending_n = det | (pending & ~(done & {N_CH{~renew}}) & (ch_en | offered));
    assign pol_n     = (det & rise & ~fall) | (~det & pol);
    assign ovf_n     = (det & (pending | offered) & ~done) | (ovf & ~ovf_clr);

    // Arbiter next state: pick the next pending channel in IDLE, hold the offer until ready
    always_comb begin
        state_n = state;
        ch_n    = evt_ch;
        rise_n  = evt_rise;
        renew_n = 1'b0;
        if (state == IDLE) begin
            if (|pending) begin
                state_n = OFFER;
                ch_n    = next_ch;
                rise_n  = pol[next_ch];
                renew_n = det[next_ch];
            end
        end else begin
            state_n = evt_ready ? IDLE : OFFER;
            renew_n = ~evt_ready & (renew | det[evt_ch]);
        end
    end

    // State, event bookkeeping and offered-event registers
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state      <= IDLE;
            pending    <= '0;
            pol        <= '0;
            ovf        <= '0;
            evt_ch     <= '0;
            evt_rise   <= 1'b0;
            renew      <= 1'b0;
            last_grant <= CH_W'(N_CH - 1);
        end else begin
            state    <= state_n;
            pending  <= pending_n;
            pol      <= pol_n;
            ovf      <= ovf_n;
            evt_ch   <= ch_n;
            evt_rise <= rise_n;
            renew    <= renew_n;
            if (state == OFFER && evt_ready)
                last_grant <= evt_ch;
        end
    end

endmodule

// File: tb/tb_edge_event_arbiter.sv
// tb_edge_event_arbiter: directed scenarios plus random traffic checked against an event-level model
module tb_edge_event_arbiter;
    localparam int N = 4;

    logic         sys_clk = 1'b0;
    logic         sys_rst = 1'b1;
    logic [N-1:0] sig_in = '0;
    logic [N-1:0] ch_en = '0;
    logic [2*N-1:0] edge_sel = '0;
    logic         evt_ready = 1'b0;
    logic [N-1:0] ovf_clr = '0;
    logic         evt_valid;
    logic [1:0]   evt_ch;
    logic         evt_rise;
    logic [N-1:0] ovf;

    edge_event_arbiter #(.N_CH(N)) dut (
        .sys_clk   (sys_clk),
        .sys_rst   (sys_rst),
        .sig_in    (sig_in),
        .ch_en     (ch_en),
        .edge_sel  (edge_sel),
        .evt_valid (evt_valid),
        .evt_ready (evt_ready),
        .evt_ch    (evt_ch),
        .evt_rise  (evt_rise),
        .ovf       (ovf),
        .ovf_clr   (ovf_clr)
    );

    always #5 sys_clk = ~sys_clk;

    // Model: hist[j] holds the input sampled j+1 edges ago (zero before reset release);
    // each channel has at most one waiting event, plus one event on offer to the consumer
    logic [N-1:0] hist [4];
    logic [N-1:0] m_wait = '0, m_wpol = '0, m_ovf = '0;
    bit           m_valid = 0, m_pol = 0;
    int           m_ch = 0, m_lg = N - 1;
    int           n_asrt = 0, n_fail = 0, ncyc = 0;
    int           hs_ch[$], hs_at[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asrt++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_step();
        logic [N-1:0] det;
        bit hs, pre_v, r, f, off, got;
        int pre_c, c;
        if (sys_rst) begin
            for (int j = 0; j < 4; j++) hist[j] = '0;
            m_wait = '0; m_wpol = '0; m_ovf = '0;
            m_valid = 0; m_ch = 0; m_pol = 0; m_lg = N - 1;
        end else begin
            hs = m_valid && evt_ready;
            pre_v = m_valid;
            pre_c = m_ch;
            for (int i = 0; i < N; i++) begin
                r = hist[2][i] && !hist[3][i];
                f = !hist[2][i] && hist[3][i];
                det[i] = ch_en[i] && ((r && edge_sel[2*i]) || (f && edge_sel[2*i+1]));
                off = pre_v && pre_c == i;
                if (det[i] && (m_wait[i] || off) && !(hs && off)) m_ovf[i] = 1'b1;
                else if (ovf_clr[i]) m_ovf[i] = 1'b0;
            end
            if (hs) begin
                m_valid = 0;
                m_lg = m_ch;
            end else if (!m_valid && m_wait != '0) begin
                got = 0;
                for (int k = 1; k <= N; k++) begin
                    c = (m_lg + k) % N;
                    if (!got && m_wait[c]) begin got = 1; m_ch = c; end
                end
                m_valid = 1;
                m_pol = m_wpol[m_ch];
                m_wait[m_ch] = 1'b0;
            end
            for (int i = 0; i < N; i++) begin
                if (det[i]) begin
                    m_wait[i] = 1'b1;
                    m_wpol[i] = hist[2][i];
                end else if (!ch_en[i] && !(pre_v && pre_c == i)) begin
                    m_wait[i] = 1'b0;
                end
            end
            for (int j = 3; j > 0; j--) hist[j] = hist[j-1];
            hist[0] = sig_in;
        end
    endtask

    task automatic cyc();
        if (evt_valid && evt_ready && !sys_rst) begin
            hs_ch.push_back(evt_ch);
            hs_at.push_back(ncyc);
        end
        @(posedge sys_clk);
        model_step();
        ncyc++;
        #1;
        chk("valid", evt_valid, m_valid);
        chk("ch", evt_ch, m_ch);
        chk("rise", evt_rise, m_pol);
        chk("ovf", ovf, m_ovf);
    endtask

    task automatic cycn(input int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    task automatic wait_valid(input int lim, output bit ok, output int n);
        ok = 0;
        n = 0;
        while (!ok && n < lim) begin
            cyc();
            n++;
            ok = evt_valid;
        end
    endtask

    initial begin
        bit ok;
        int n, n0;
        // reset
        cycn(2);
        sys_rst = 0;
        cyc();
        chk("rst_valid", evt_valid, 0);
        chk("rst_ovf", ovf, 0);

        // single rise on channel 0
        ch_en = 4'b0001; edge_sel = 8'h01; evt_ready = 1;
        cycn(3);
        hs_ch.delete(); hs_at.delete();
        sig_in = 4'b0001;
        wait_valid(10, ok, n);
        chk("single_found", ok, 1);
        chk("single_latency", n - 1, 4);
        chk("single_ch", evt_ch, 0);
        chk("single_rise", evt_rise, 1);
        cycn(6);
        chk("single_count", hs_ch.size(), 1);
        chk("single_ovf", ovf, 0);

        // round-robin from a fresh reset
        ch_en = 4'hF; edge_sel = 8'h55; sig_in = 4'h0;
        sys_rst = 1; cyc(); sys_rst = 0;
        cycn(5);
        hs_ch.delete(); hs_at.delete();
        sig_in = 4'hF;
        cycn(14);
        chk("rr_count", hs_ch.size(), 4);
        for (int i = 0; i < 4 && i < hs_ch.size(); i++) chk("rr_order", hs_ch[i], i);
        for (int i = 1; i < 4 && i < hs_at.size(); i++) chk("rr_spacing", hs_at[i] - hs_at[i-1], 2);

        // backpressure and overflow on channel 2
        ch_en = 4'b0100; edge_sel = 8'h10; sig_in = 4'h0;
        cycn(6);
        edge_sel = 8'h30; evt_ready = 0; sig_in = 4'b0100;
        cycn(3);
        sig_in = 4'b0000;
        cycn(7);
        chk("bp_valid", evt_valid, 1);
        chk("bp_ch", evt_ch, 2);
        chk("bp_rise", evt_rise, 1);
        chk("bp_ovf", ovf, 4'b0100);
        evt_ready = 1;
        cyc();
        wait_valid(6, ok, n);
        chk("bp_second_found", ok, 1);
        chk("bp_second_ch", evt_ch, 2);
        chk("bp_second_rise", evt_rise, 0);
        cycn(3);
        ovf_clr = 4'b0100;
        cyc();
        ovf_clr = 4'b0000;
        chk("bp_ovf_clr", ovf, 0);

        // handshake coinciding with a new edge on channel 1
        ch_en = 4'b0010; edge_sel = 8'h0C; evt_ready = 0; sig_in = 4'b0010;
        cycn(6);
        chk("sim_valid", evt_valid, 1);
        chk("sim_ch", evt_ch, 1);
        sig_in = 4'b0000;
        cycn(3);
        evt_ready = 1;
        cyc();
        evt_ready = 0;
        chk("sim_gap", evt_valid, 0);
        chk("sim_ovf", ovf, 0);
        cyc();
        chk("sim_again", evt_valid, 1);
        chk("sim_again_ch", evt_ch, 1);
        chk("sim_again_rise", evt_rise, 0);
        evt_ready = 1;
        cyc();
        evt_ready = 0;
        cycn(3);

        // disable drops a waiting event; fall-only mode
        ch_en = 4'b1100; edge_sel = 8'h50; sig_in = 4'b1100;
        cycn(6);
        chk("dis_ch", evt_ch, 2);
        ch_en = 4'b0100;
        cycn(2);
        evt_ready = 1;
        n0 = hs_ch.size();
        cycn(7);
        chk("dis_count", hs_ch.size() - n0, 1);
        chk("dis_idle", evt_valid, 0);
        ch_en = 4'b1000; edge_sel = 8'h80; sig_in = 4'b0100;
        wait_valid(10, ok, n);
        chk("fall_found", ok, 1);
        chk("fall_ch", evt_ch, 3);
        chk("fall_rise", evt_rise, 0);
        cycn(3);
        n0 = hs_ch.size();
        sig_in = 4'b1100;
        cycn(8);
        chk("rise_ignored", hs_ch.size() - n0, 0);

        // reset in the middle of an offer
        ch_en = 4'b0001; edge_sel = 8'h01; evt_ready = 0; sig_in = 4'b1101;
        cycn(6);
        chk("mid_valid", evt_valid, 1);
        sys_rst = 1;
        cyc();
        sys_rst = 0;
        chk("mid_rst_valid", evt_valid, 0);
        chk("mid_rst_ovf", ovf, 0);
        wait_valid(12, ok, n);
        chk("mid_fresh", ok, 1);
        chk("mid_fresh_ch", evt_ch, 0);
        chk("mid_fresh_rise", evt_rise, 1);
        evt_ready = 1;
        cycn(2);

        // random traffic
        for (int t = 0; t < 3000; t++) begin
            for (int i = 0; i < N; i++) if ($urandom_range(0, 3) == 0) sig_in[i] = ~sig_in[i];
            if ($urandom_range(0, 31) == 0) ch_en = N'($urandom);
            if ($urandom_range(0, 31) == 0) edge_sel = 8'($urandom);
            for (int i = 0; i < N; i++) ovf_clr[i] = $urandom_range(0, 15) == 0;
            evt_ready = $urandom_range(0, 1) == 1;
            sys_rst = $urandom_range(0, 499) == 0;
            cyc();
        end
        sys_rst = 0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
        $finish;
    end

endmodule
